// File: rtl/elev_ctrl_n.sv
// SCAN elevator car controller: latches car/hall calls, steps one floor per MOVE_TICKS clocks,
// holds the door for DOOR_TICKS clocks. Optional door-hold input under `ELEV_DOOR_HOLD_EN.
module elev_ctrl_n #(
   parameter int FLOORS     = 4,
   parameter int MOVE_TICKS = 8,
   parameter int DOOR_TICKS = 4,
   localparam int FW        = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLOORS-1:0] car_req_n,
   input  logic [FLOORS-1:0] hall_req_n,
`ifdef ELEV_DOOR_HOLD_EN
   input  logic              door_hold_n,
`endif
   output logic [FW-1:0]     floor,
   output logic              moving,
   output logic              dir_up,
   output logic              door_open,
   output logic [FLOORS-1:0] pending
);

   localparam int CMAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] MOVE_LD = CW'(MOVE_TICKS - 1);
   localparam logic [CW-1:0] DOOR_LD = CW'(DOOR_TICKS - 1);
   localparam logic [FW-1:0] TOP     = FW'(FLOORS - 1);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     floor_q, floor_d;
   logic              dir_up_q, dir_up_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [FLOORS-1:0] pending_q, pending_d;
   logic              eff_up, door_hold;

   // Any outstanding request strictly beyond floor f in the given direction.
   function automatic logic req_dir(input logic [FLOORS-1:0] p, input logic [FW-1:0] f,
                                    input logic up);
      req_dir = 1'b0;
      for (int i = 0; i < FLOORS; i++)
         if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) req_dir = 1'b1;
   endfunction

`ifdef ELEV_DOOR_HOLD_EN
   assign door_hold = ~door_hold_n;
`else
   assign door_hold = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_up_d  = dir_up_q;
      cnt_d     = cnt_q;
      // End floors force the only legal direction before the car leaves IDLE.
      eff_up    = (floor_q == TOP) ? 1'b0 : (floor_q == '0) ? 1'b1 : dir_up_q;
      case (state_q)
         IDLE: begin
            if (pending_q[floor_q]) begin
               state_d  = DOOR;
               cnt_d    = DOOR_LD;
               dir_up_d = eff_up;
            end else if (req_dir(pending_q, floor_q, eff_up)) begin
               state_d  = MOVE;
               cnt_d    = MOVE_LD;
               dir_up_d = eff_up;
            end else if (req_dir(pending_q, floor_q, ~eff_up)) begin
               state_d  = MOVE;
               cnt_d    = MOVE_LD;
               dir_up_d = ~eff_up;
            end
         end
         MOVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (dir_up_q ? (floor_q == TOP) : (floor_q == '0)) begin
               state_d = IDLE;
            end else begin
               floor_d = dir_up_q ? floor_q + FW'(1) : floor_q - FW'(1);
               if (pending_q[floor_d]) begin
                  state_d = DOOR;
                  cnt_d   = DOOR_LD;
               end else if (req_dir(pending_q, floor_d, dir_up_q)) begin
                  cnt_d   = MOVE_LD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         DOOR: begin
            if (door_hold)          cnt_d = DOOR_LD;
            else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
            else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Clearing the served floor wins over a press of the same floor.
      pending_d = pending_q | ~car_req_n | ~hall_req_n;
      if (state_d == DOOR || state_q == DOOR) pending_d[floor_d] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         floor_q   <= '0;
         dir_up_q  <= 1'b1;
         cnt_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         dir_up_q  <= dir_up_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   assign floor     = floor_q;
   assign moving    = (state_q == MOVE);
   assign dir_up    = dir_up_q;
   assign door_open = (state_q == DOOR);
   assign pending   = pending_q;

endmodule

// File: tb/tb_elev_ctrl_n.sv
// Directed table-driven bench for elev_ctrl_n (defaults 4/8/4) plus hand sequences for
// door duration, reset mid-door and, when ELEV_DOOR_HOLD_EN is defined, the door hold.
module tb_elev_ctrl_n;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] car_req_n, hall_req_n;
   logic [1:0] floor;
   logic       moving, dir_up, door_open;
   logic [3:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
   logic       door_hold_n = 1'b1;
`endif

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   elev_ctrl_n dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .car_req_n  (car_req_n),
      .hall_req_n (hall_req_n),
`ifdef ELEV_DOOR_HOLD_EN
      .door_hold_n(door_hold_n),
`endif
      .floor      (floor),
      .moving     (moving),
      .dir_up     (dir_up),
      .door_open  (door_open),
      .pending    (pending)
   );

   typedef struct {
      logic       rst_n;
      logic [3:0] car, hall;
      int         n;
      logic [1:0] f;
      logic       mv, up, dr;
      logic [3:0] p;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic [3:0] c, input logic [3:0] h,
                               input int n, input logic [1:0] f, input logic mv,
                               input logic up, input logic dr, input logic [3:0] p);
      vec_t v;
      v.rst_n = r; v.car = c; v.hall = h; v.n = n;
      v.f = f; v.mv = mv; v.up = up; v.dr = dr; v.p = p;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s (step %0d): got %0h expected %0h", nm, id, act, exp);
      end
   endtask

   task automatic wait_door(input int id, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (door_open) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errs++;
         $display("FAIL door_timeout (seq %0d): got door_open=0 expected 1 within 200 clks", id);
      end
   endtask

   task automatic count_open(inout int n);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (door_open) n++;
         else break;
      end
   endtask

   initial begin
      bit ok;
      int n;
      //  rst car     hall    n   f  mv up dr pend
      add(0, 4'b0000, 4'b0000, 2, 0, 0, 1, 0, 4'b0000); // reset with keys held
      add(1, 4'b1011, 4'b1111, 1, 0, 0, 1, 0, 4'b0100); // press 2, latched next clk
      add(1, 4'b1111, 4'b1111, 1, 0, 1, 1, 0, 4'b0100); // MOVE starts
      add(1, 4'b1111, 4'b1111, 7, 0, 1, 1, 0, 4'b0100);
      add(1, 4'b1111, 4'b1111, 1, 1, 1, 1, 0, 4'b0100); // floor 1 after 8
      add(1, 4'b1111, 4'b1111, 7, 1, 1, 1, 0, 4'b0100);
      add(1, 4'b1111, 4'b1111, 1, 2, 0, 1, 1, 4'b0000); // floor 2 after 16, door
      add(1, 4'b1111, 4'b1111, 3, 2, 0, 1, 1, 4'b0000);
      add(1, 4'b1111, 4'b1111, 1, 2, 0, 1, 0, 4'b0000); // door closed after 4
      add(1, 4'b1110, 4'b0111, 1, 2, 0, 1, 0, 4'b1001); // hall 3 + car 0
      add(1, 4'b1111, 4'b1111, 1, 2, 1, 1, 0, 4'b1001);
      add(1, 4'b1111, 4'b1111, 8, 3, 0, 1, 1, 4'b0001); // serve 3 first
      add(1, 4'b1111, 4'b1111, 4, 3, 0, 1, 0, 4'b0001);
      add(1, 4'b1111, 4'b1111, 1, 3, 1, 0, 0, 4'b0001); // reverse at top
      add(1, 4'b1111, 4'b1111, 8, 2, 1, 0, 0, 4'b0001); // pass 2, no stop
      add(1, 4'b1111, 4'b1111, 8, 1, 1, 0, 0, 4'b0001);
      add(1, 4'b1111, 4'b1111, 8, 0, 0, 0, 1, 4'b0000); // door at 0
      add(1, 4'b1111, 4'b1111, 4, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0111, 4'b1111, 1, 0, 0, 0, 0, 4'b1000); // request top floor
      add(1, 4'b1111, 4'b1111, 1, 0, 1, 1, 0, 4'b1000); // dir forced up at 0
      add(1, 4'b1111, 4'b1111, 24, 3, 0, 1, 1, 4'b0000);
      add(1, 4'b1111, 4'b1111, 4, 3, 0, 1, 0, 4'b0000);
      add(1, 4'b1101, 4'b1111, 1, 3, 0, 1, 0, 4'b0010); // idle at top, press 1
      add(1, 4'b1111, 4'b1111, 1, 3, 1, 0, 0, 4'b0010); // dir forced down
      add(1, 4'b1111, 4'b1111, 8, 2, 1, 0, 0, 4'b0010);
      add(1, 4'b1111, 4'b1111, 8, 1, 0, 0, 1, 4'b0000);
      add(1, 4'b1100, 4'b1111, 1, 1, 0, 0, 1, 4'b0001); // press 1 (dropped) and 0 in DOOR
      add(1, 4'b1111, 4'b1111, 2, 1, 0, 0, 1, 4'b0001);
      add(1, 4'b1111, 4'b1111, 1, 1, 0, 0, 0, 4'b0001);
      add(1, 4'b1111, 4'b1111, 1, 1, 1, 0, 0, 4'b0001); // floor 0 served after
      add(1, 4'b1111, 4'b1111, 8, 0, 0, 0, 1, 4'b0000);
      add(1, 4'b1111, 4'b1111, 4, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b1011, 4'b1111, 1, 0, 0, 0, 0, 4'b0100);
      add(1, 4'b1111, 4'b1111, 1, 0, 1, 1, 0, 4'b0100);
      add(1, 4'b1111, 4'b1111, 8, 1, 1, 1, 0, 4'b0100);
      add(1, 4'b1111, 4'b1111, 4, 1, 1, 1, 0, 4'b0100); // mid 1->2
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 0, 4'b0000); // reset aborts move
      add(1, 4'b1111, 4'b1111, 1, 0, 0, 1, 0, 4'b0000);

      for (int s = 0; s < tbl.size(); s++) begin
         rst_n      = tbl[s].rst_n;
         car_req_n  = tbl[s].car;
         hall_req_n = tbl[s].hall;
         repeat (tbl[s].n) @(posedge clk);
         @(negedge clk);
         chk("floor",     s, 32'(floor),     32'(tbl[s].f));
         chk("moving",    s, 32'(moving),    32'(tbl[s].mv));
         chk("dir_up",    s, 32'(dir_up),    32'(tbl[s].up));
         chk("door_open", s, 32'(door_open), 32'(tbl[s].dr));
         chk("pending",   s, 32'(pending),   32'(tbl[s].p));
      end

      // Door length measured end to end: floor 0 -> 2.
      car_req_n = 4'b1011;
      @(negedge clk);
      car_req_n = 4'b1111;
      wait_door(1, ok);
      if (ok) begin
         chk("door_floor", 100, 32'(floor), 32'd2);
         n = 1;
         count_open(n);
         chk("door_len", 100, 32'(n), 32'd4);
      end

      // Reset in the middle of a door cycle.
      car_req_n = 4'b1011;
      @(negedge clk);
      car_req_n = 4'b1111;
      wait_door(2, ok);
      if (ok) begin
         @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         chk("rst_door_open", 101, 32'(door_open), 32'd0);
         chk("rst_door_floor", 101, 32'(floor), 32'd0);
         @(negedge clk);
         chk("rst_door_idle", 101, 32'({moving, door_open}), 32'd0);
      end

`ifdef ELEV_DOOR_HOLD_EN
      // Door held for 10 clocks, then full count after release.
      car_req_n = 4'b1101;
      @(negedge clk);
      car_req_n = 4'b1111;
      wait_door(3, ok);
      if (ok) begin
         n = 1;
         door_hold_n = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (door_open) n++;
         end
         door_hold_n = 1'b1;
         count_open(n);
         chk("hold_len", 102, 32'(n), 32'd14);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
